// File: rtl/arm_prog_loader_if.sv
// Stream, core-side and memory-side signals of the program loader.
// The loader connects through the slave modport; the environment connects through master.
interface arm_prog_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] core_mem_addr;
    logic [DATA_W-1:0] core_mem_data_in;
    logic              core_mem_write_en;
    logic              core_halted;
    logic              core_rst;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_en;

    modport slave (
        input  in_valid, in_data, in_last,
        input  core_mem_addr, core_mem_data_in, core_mem_write_en, core_halted,
        output in_ready, core_rst, mem_addr, mem_data_in, mem_write_en
    );

    modport master (
        output in_valid, in_data, in_last,
        output core_mem_addr, core_mem_data_in, core_mem_write_en, core_halted,
        input  in_ready, core_rst, mem_addr, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/arm_prog_loader.sv
// Program loader and run controller: streams words into memory with the core held
// in reset, then hands the memory port to the core and supervises its run.
module arm_prog_loader #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       MAX_WORDS   = 1024,
    parameter int unsigned       TIMEOUT_CYC = 100000,
    parameter int unsigned       CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    arm_prog_loader_if.slave bus,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] words_loaded,
    output logic [CNT_W-1:0] run_cycles,
    output logic             done,
    output logic             timeout,
    output logic             load_err
);
    localparam int unsigned       BYTES_PER_WORD = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STRIDE         = ADDR_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  MAX_CNT        = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0]  TO_LAST        = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALTED  = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              load_err_q, load_err_d;

    logic accept;
    logic full;
    logic to_hit;

    assign accept = bus.in_valid && (state_q == ST_LOAD);
    assign full   = (words_q >= MAX_CNT);
    assign to_hit = (TIMEOUT_CYC != 0) && (run_q == TO_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_LOAD;
        else     state_q <= state_d;
    end

    // Next-state logic; halt takes priority over timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (full)             state_d = ST_ERROR;
                    else if (bus.in_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.core_halted) state_d = ST_HALTED;
                else if (to_hit)     state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    // Datapath next values: load writes, counters and sticky flags
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        words_d    = words_q;
        run_d      = run_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        load_err_d = load_err_q;
        core_rst_d = (state_d != ST_RUN);
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (full) begin
                        load_err_d = 1'b1;
                    end else begin
                        mem_addr_d = BASE_ADDR + ADDR_W'(words_q) * STRIDE;
                        mem_data_d = bus.in_data;
                        mem_we_d   = 1'b1;
                        words_d    = words_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (run_q != '1) run_d = run_q + CNT_W'(1);
                if (bus.core_halted) done_d = 1'b1;
                else if (to_hit)     timeout_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            words_q    <= '0;
            run_q      <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            words_q    <= words_d;
            run_q      <= run_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            load_err_q <= load_err_d;
        end
    end

    // Outputs; in RUN the memory port is a straight pass-through from the core
    always_comb begin
        bus.in_ready = (state_q == ST_LOAD);
        bus.core_rst = core_rst_q;
        if (state_q == ST_RUN) begin
            bus.mem_addr     = bus.core_mem_addr;
            bus.mem_data_in  = bus.core_mem_data_in;
            bus.mem_write_en = bus.core_mem_write_en;
        end else begin
            bus.mem_addr     = mem_addr_q;
            bus.mem_data_in  = mem_data_q;
            bus.mem_write_en = mem_we_q;
        end
        state        = state_q;
        words_loaded = words_q;
        run_cycles   = run_q;
        done         = done_q;
        timeout      = timeout_q;
        load_err     = load_err_q;
    end
endmodule

// File: doc/arm_prog_loader.md
Name: arm_prog_loader

Overview:
- Synthesizable program loader and run controller between a word stream source, `arm_memory`'s data port and `arm_core`.
- Holds the core in reset and streams words into memory at incrementing byte addresses. After the last word is committed, it hands the memory port to the core and releases core reset.
- Monitors `halted`, counts run cycles, and flags timeout or load overflow.
- Generalises the load-then-run bring-up sequence: parametrised data width, base address, capacity and timeout, with a registered stream handshake.

Parameters:
- DATA_W, 32, memory word width in bits; multiple of 8.
- ADDR_W, 32, byte address width.
- BASE_ADDR, 0, byte address of the first loaded word.
- MAX_WORDS, 1024, load capacity in words.
- TIMEOUT_CYC, 100000, run cycles before timeout; 0 disables timeout.
- CNT_W, 32, width of the cycle and word counters.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_last  in  1  marks the final word of the program.
- in_ready  out  1  loader accepts a word this cycle.
- core_mem_addr  in  ADDR_W  core data address.
- core_mem_data_in  in  DATA_W  core write data.
- core_mem_write_en  in  1  core write enable.
- core_halted  in  1  core halted flag.
- core_rst  out  1  reset to the core.
- mem_addr  out  ADDR_W  memory data-port address.
- mem_data_in  out  DATA_W  memory write data.
- mem_write_en  out  1  memory write enable.
- state  out  3  encoded FSM state.
- words_loaded  out  CNT_W  words committed to memory.
- run_cycles  out  CNT_W  cycles spent in RUN.
- done  out  1  core halted normally (sticky).
- timeout  out  1  run exceeded TIMEOUT_CYC (sticky).
- load_err  out  1  stream overflowed MAX_WORDS (sticky).

Behaviour:
- States and encodings: LOAD=0, DRAIN=1, RUN=2, HALTED=3, TIMEOUT=4, ERROR=5.
- Reset (async):
  - state=LOAD.
  - core_rst=1; mem_write_en=0; mem_addr=0; mem_data_in=0.
  - words_loaded=0; run_cycles=0.
  - done=0; timeout=0; load_err=0.
- in_ready:
  - Equals 1 only when state==LOAD; combinational from state.
  - A word is accepted on any edge where in_valid && in_ready.
- LOAD:
  - Accepted word with words_loaded < MAX_WORDS, registered 1-cycle write:
    - mem_addr <= BASE_ADDR + words_loaded*(DATA_W/8), truncated to ADDR_W.
    - mem_data_in <= in_data.
    - mem_write_en <= 1.
    - words_loaded <= words_loaded + 1.
  - No accepted word: mem_write_en <= 0.
  - Accepted word with in_last=1: next state DRAIN.
  - Accepted word when words_loaded == MAX_WORDS: no write; load_err <= 1; next state ERROR.
- DRAIN:
  - Lasts exactly one cycle, during which the final write completes.
  - mem_write_en <= 0; next state RUN.
  - core_rst stays 1 during DRAIN.
- RUN:
  - core_rst=0.
  - mem_addr, mem_data_in and mem_write_en are driven combinationally from the core_* inputs.
  - run_cycles increments each RUN cycle, saturating at all-ones.
  - core_halted=1: next state HALTED; done <= 1.
  - Otherwise, TIMEOUT_CYC != 0 and run_cycles == TIMEOUT_CYC-1: next state TIMEOUT; timeout <= 1.
  - halted and the timeout condition in the same cycle: HALTED wins.
- HALTED / TIMEOUT / ERROR:
  - Terminal; left only via rst.
  - core_rst=1; mem_write_en=0.
  - Counters frozen.
- Ignored inputs:
  - in_valid outside LOAD is ignored; no write, no error.
  - in_last on a rejected (overflow) word is ignored.
- rst asserted mid-load or mid-run: immediate return to reset values. Memory contents already written are not cleared.
- Terminal-state register outputs: words_loaded and run_cycles hold their final values until rst.

Test Plan:
- Stream 4 words 0x11111111..0x44444444, last on the 4th, BASE_ADDR=0 -> writes at addresses 0,4,8,12 each 1 cycle after acceptance; DRAIN for 1 cycle; core_rst falls 2 cycles after the last acceptance; words_loaded=4.
- In RUN, drive core_mem_addr=0x40, core_mem_write_en=1 -> mem_addr=0x40 and mem_write_en=1 in the same cycle. Raise core_halted after 10 RUN cycles -> state=HALTED, done=1, run_cycles=10, core_rst=1.
- TIMEOUT_CYC=8, halted never asserted -> TIMEOUT entered after 8 RUN cycles, timeout=1, core_rst=1.
- MAX_WORDS=2, stream 3 words without in_last -> 2 writes; load_err=1; state=ERROR; no third write; in_ready=0.
- Assert rst during LOAD after 2 words, then reload 1 word with in_last -> write at BASE_ADDR; words_loaded=1.
- Toggle in_valid while in RUN -> in_ready=0; memory writes come only from the core_* inputs.
